// File: rtl/branch_predictor_bht_pkg.sv
// Shared constants and helpers for the branch history table.
`include "defines.sv"
package bp_pkg;
    localparam int ADDRESS_LEN_DEFAULT = `ADDRESS_LEN;
    localparam int STAT_WIDTH_DEFAULT  = 16;
    localparam int MAX_HIST_LEN        = 32;

    // Weakly-not-taken: one below the taken/not-taken midpoint.
    function automatic int ctr_init(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

    // Bimodal mode still carries a 1-bit history field so ports never collapse to zero width.
    function automatic int ghr_width(input int hist_len);
        return (hist_len > 1) ? hist_len : 1;
    endfunction

    typedef logic [MAX_HIST_LEN-1:0] ghr_max_t;
endpackage

// File: rtl/branch_predictor_bht_if.sv
// Lookup/update/statistics bundle between the ID/EX pipeline and the predictor.
interface branch_predictor_bht_if
    import bp_pkg::*;
#(
    parameter int ADDRESS_LEN = ADDRESS_LEN_DEFAULT,
    parameter int INDEX_BITS  = 4,
    parameter int HIST_LEN    = 0,
    parameter int STAT_WIDTH  = STAT_WIDTH_DEFAULT
);
    localparam int HIST_W = ghr_width(HIST_LEN);

    logic                   lookup_valid;
    logic [ADDRESS_LEN-1:0] lookup_pc;
    logic                   predict_taken;
    logic [INDEX_BITS-1:0]  predict_index;
    logic [HIST_W-1:0]      predict_hist;
    logic                   update_valid;
    logic [INDEX_BITS-1:0]  update_index;
    logic [HIST_W-1:0]      update_hist;
    logic                   update_taken;
    logic                   update_predicted;
    logic                   mispredict;
    logic [STAT_WIDTH-1:0]  lookup_count;
    logic [STAT_WIDTH-1:0]  mispredict_count;

    modport master (
        output lookup_valid, lookup_pc,
        output update_valid, update_index, update_hist, update_taken, update_predicted,
        input  predict_taken, predict_index, predict_hist,
        input  mispredict, lookup_count, mispredict_count
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        input  update_valid, update_index, update_hist, update_taken, update_predicted,
        output predict_taken, predict_index, predict_hist,
        output mispredict, lookup_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_bht_sat_counter.sv
// Unsigned saturating up/down counter; increment has priority over decrement.
module sat_counter #(
    parameter int               WIDTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= RESET_VAL;
        end else if (i_inc) begin
            if (r_count != '1) r_count <= r_count + 1'b1;
        end else if (i_dec) begin
            if (r_count != '0) r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/defines.sv
// Project-wide defines shared by the datapath blocks.
`ifndef BP_DEFINES_SV
`define BP_DEFINES_SV
`define ADDRESS_LEN 12
`endif

// File: rtl/branch_predictor_bht.sv
// Bimodal/gshare direction predictor: combinational lookup in ID, counter update from EX,
// speculative GHR repaired on mispredict, saturating lookup/mispredict statistics.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int ADDRESS_LEN = ADDRESS_LEN_DEFAULT,
    parameter int INDEX_BITS  = 4,
    parameter int CTR_BITS    = 2,
    parameter int HIST_LEN    = 0,
    parameter int STAT_WIDTH  = STAT_WIDTH_DEFAULT
) (
    input logic                   clk,
    input logic                   rst,
    branch_predictor_bht_if.slave bp
);
    localparam int                ENTRIES = 1 << INDEX_BITS;
    localparam int                HIST_W  = ghr_width(HIST_LEN);
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_init(CTR_BITS));

    typedef logic [HIST_W-1:0] ghr_t;

    logic [CTR_BITS-1:0]   w_ctr [ENTRIES];
    ghr_t                  w_ghr;
    logic [INDEX_BITS-1:0] w_lookup_idx;
    logic                  w_pred_taken;
    logic                  w_mispredict;
    logic                  w_unused;

    assign w_lookup_idx = bp.lookup_pc[INDEX_BITS-1:0] ^ INDEX_BITS'(w_ghr);
    assign w_pred_taken = w_ctr[w_lookup_idx][CTR_BITS-1];
    assign w_mispredict = bp.update_valid && (bp.update_taken != bp.update_predicted);

    assign bp.predict_taken = w_pred_taken;
    assign bp.predict_index = w_lookup_idx;
    assign bp.predict_hist  = w_ghr;
    assign bp.mispredict    = w_mispredict;

    assign w_unused = &{1'b0, bp.lookup_pc[ADDRESS_LEN-1:INDEX_BITS], bp.update_hist};

    // Lookups read the pre-edge counter; an update to the same entry lands at the edge.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_table
        logic w_en;
        assign w_en = bp.update_valid && (bp.update_index == INDEX_BITS'(gi));

        sat_counter #(
            .WIDTH     (CTR_BITS),
            .RESET_VAL (CTR_RST)
        ) u_ctr (
            .clk     (clk),
            .rst     (rst),
            .i_inc   (w_en & bp.update_taken),
            .i_dec   (w_en & ~bp.update_taken),
            .o_count (w_ctr[gi])
        );
    end

    if (HIST_LEN > 0) begin : g_ghr
        ghr_t r_ghr;
        ghr_t w_ghr_nxt;

        // A mispredict flushes the lookup in ID, so repair beats speculative shift.
        always_comb begin
            w_ghr_nxt = r_ghr;
            if (w_mispredict) begin
                w_ghr_nxt = HIST_W'({bp.update_hist, bp.update_taken});
            end else if (bp.lookup_valid) begin
                w_ghr_nxt = HIST_W'({r_ghr, w_pred_taken});
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) r_ghr <= '0;
            else      r_ghr <= w_ghr_nxt;
        end

        assign w_ghr = r_ghr;
    end else begin : g_no_ghr
        assign w_ghr = '0;
    end

    sat_counter #(
        .WIDTH     (STAT_WIDTH),
        .RESET_VAL ('0)
    ) u_lookup_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (bp.lookup_valid),
        .i_dec   (1'b0),
        .o_count (bp.lookup_count)
    );

    sat_counter #(
        .WIDTH     (STAT_WIDTH),
        .RESET_VAL ('0)
    ) u_mispredict_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_mispredict),
        .i_dec   (1'b0),
        .o_count (bp.mispredict_count)
    );
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bimodal (16-bit stats) and gshare (HIST_LEN=4, 4-bit stats) predictors against a table model.
module tb_branch_predictor_bht;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_bht_if #(.ADDRESS_LEN(12), .INDEX_BITS(4), .HIST_LEN(0), .STAT_WIDTH(16)) bus_b ();
    branch_predictor_bht_if #(.ADDRESS_LEN(12), .INDEX_BITS(4), .HIST_LEN(4), .STAT_WIDTH(4))  bus_g ();

    branch_predictor_bht #(.ADDRESS_LEN(12), .INDEX_BITS(4), .CTR_BITS(2), .HIST_LEN(0), .STAT_WIDTH(16))
        u_bim (.clk(clk), .rst(rst_n), .bp(bus_b));
    branch_predictor_bht #(.ADDRESS_LEN(12), .INDEX_BITS(4), .CTR_BITS(2), .HIST_LEN(4), .STAT_WIDTH(4))
        u_gsh (.clk(clk), .rst(rst_n), .bp(bus_g));

    int checks = 0;
    int failures = 0;

    // Reference state: [0]=bimodal, [1]=gshare.
    int ctr [2][16];
    int ghr [2];
    int lc  [2];
    int mc  [2];
    int hl   [2] = '{0, 4};
    int smax [2] = '{65535, 15};

    int last_pt, last_idx, last_hist, last_mp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int e = 0; e < 16; e++) ctr[s][e] = 1;
            ghr[s] = 0;
            lc[s]  = 0;
            mc[s]  = 0;
        end
    endtask

    task automatic idle_all();
        bus_b.lookup_valid = 0; bus_b.lookup_pc = '0; bus_b.update_valid = 0; bus_b.update_index = '0;
        bus_b.update_hist = '0; bus_b.update_taken = 0; bus_b.update_predicted = 0;
        bus_g.lookup_valid = 0; bus_g.lookup_pc = '0; bus_g.update_valid = 0; bus_g.update_index = '0;
        bus_g.update_hist = '0; bus_g.update_taken = 0; bus_g.update_predicted = 0;
    endtask

    // One clock of stimulus on instance s: drive, check combinational outputs, clock, advance model.
    task automatic cyc(input int s, input int lv, input int pc, input int uv, input int ui,
                       input int uh, input int ut, input int up);
        int idx, pt, mp;
        idle_all();
        if (s == 0) begin
            bus_b.lookup_valid = 1'(lv); bus_b.lookup_pc = 12'(pc); bus_b.update_valid = 1'(uv);
            bus_b.update_index = 4'(ui); bus_b.update_hist = 1'(uh);
            bus_b.update_taken = 1'(ut); bus_b.update_predicted = 1'(up);
        end else begin
            bus_g.lookup_valid = 1'(lv); bus_g.lookup_pc = 12'(pc); bus_g.update_valid = 1'(uv);
            bus_g.update_index = 4'(ui); bus_g.update_hist = 4'(uh);
            bus_g.update_taken = 1'(ut); bus_g.update_predicted = 1'(up);
        end
        #1;
        idx = (pc % 16) ^ ghr[s];
        pt  = (ctr[s][idx] >= 2) ? 1 : 0;
        mp  = (uv != 0 && ut != up) ? 1 : 0;
        if (s == 0) begin
            last_pt = int'(bus_b.predict_taken); last_idx = int'(bus_b.predict_index);
            last_hist = int'(bus_b.predict_hist); last_mp = int'(bus_b.mispredict);
            chk("b_predict_taken", 32'(bus_b.predict_taken), 32'(pt));
            chk("b_predict_index", 32'(bus_b.predict_index), 32'(idx));
            chk("b_predict_hist",  32'(bus_b.predict_hist),  32'(0));
            chk("b_mispredict",    32'(bus_b.mispredict),    32'(mp));
            chk("b_lookup_count",  32'(bus_b.lookup_count),  32'(lc[0]));
            chk("b_mispred_count", 32'(bus_b.mispredict_count), 32'(mc[0]));
        end else begin
            last_pt = int'(bus_g.predict_taken); last_idx = int'(bus_g.predict_index);
            last_hist = int'(bus_g.predict_hist); last_mp = int'(bus_g.mispredict);
            chk("g_predict_taken", 32'(bus_g.predict_taken), 32'(pt));
            chk("g_predict_index", 32'(bus_g.predict_index), 32'(idx));
            chk("g_predict_hist",  32'(bus_g.predict_hist),  32'(ghr[1]));
            chk("g_mispredict",    32'(bus_g.mispredict),    32'(mp));
            chk("g_lookup_count",  32'(bus_g.lookup_count),  32'(lc[1]));
            chk("g_mispred_count", 32'(bus_g.mispredict_count), 32'(mc[1]));
        end
        @(posedge clk);
        #1;
        if (uv != 0) begin
            if (ut != 0) ctr[s][ui % 16] = (ctr[s][ui % 16] == 3) ? 3 : ctr[s][ui % 16] + 1;
            else         ctr[s][ui % 16] = (ctr[s][ui % 16] == 0) ? 0 : ctr[s][ui % 16] - 1;
        end
        if (hl[s] > 0) begin
            if (mp != 0)      ghr[s] = ((uh * 2) + (ut != 0 ? 1 : 0)) % 16;
            else if (lv != 0) ghr[s] = ((ghr[s] * 2) + pt) % 16;
        end
        if (lv != 0 && lc[s] < smax[s]) lc[s]++;
        if (mp != 0 && mc[s] < smax[s]) mc[s]++;
    endtask

    task automatic rand_cyc(input int s);
        cyc(s, int'($urandom_range(0, 1)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    endtask

    initial begin
        model_reset();
        idle_all();
        bus_b.lookup_pc = 12'h005;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_b_pt",    32'(bus_b.predict_taken), 32'(0));
        chk("rst_b_idx",   32'(bus_b.predict_index), 32'(5));
        chk("rst_b_lc",    32'(bus_b.lookup_count),  32'(0));
        chk("rst_g_hist",  32'(bus_g.predict_hist),  32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Bimodal training, saturation and mispredict counting at index 5.
        cyc(0, 1, 12'h005, 0, 0, 0, 0, 0);
        chk("plan_init_pt", 32'(last_pt), 32'(0));
        chk("plan_init_idx", 32'(last_idx), 32'(5));
        cyc(0, 0, 0, 1, 5, 0, 1, 0);
        chk("plan_mispredict", 32'(last_mp), 32'(1));
        chk("plan_mc_after", 32'(bus_b.mispredict_count), 32'(1));
        cyc(0, 0, 0, 1, 5, 0, 1, 1);
        cyc(0, 1, 12'h005, 0, 0, 0, 0, 0);
        chk("plan_trained_pt", 32'(last_pt), 32'(1));
        cyc(0, 0, 0, 1, 5, 0, 1, 1);
        cyc(0, 0, 0, 1, 5, 0, 0, 1);
        cyc(0, 1, 12'h005, 0, 0, 0, 0, 0);
        chk("plan_weak_taken_pt", 32'(last_pt), 32'(1));
        cyc(0, 0, 0, 1, 5, 0, 0, 1);
        cyc(0, 1, 12'h005, 0, 0, 0, 0, 0);
        chk("plan_back_to_nt_pt", 32'(last_pt), 32'(0));

        // Same-entry collision: lookup sees the pre-update counter.
        cyc(0, 1, 12'h007, 1, 7, 0, 1, 0);
        chk("plan_collision_pt", 32'(last_pt), 32'(0));
        cyc(0, 1, 12'h007, 0, 0, 0, 0, 0);
        chk("plan_collision_next", 32'(last_pt), 32'(1));

        // Gshare history shift and repair.
        cyc(1, 0, 0, 1, 3, 0, 1, 1);
        cyc(1, 0, 0, 1, 3, 0, 1, 1);
        cyc(1, 1, 12'h003, 0, 0, 0, 0, 0);
        chk("plan_g_pt", 32'(last_pt), 32'(1));
        chk("plan_g_ghr1", 32'(bus_g.predict_hist), 32'(1));
        cyc(1, 1, 12'h003, 0, 0, 0, 0, 0);
        chk("plan_g_idx2", 32'(last_idx), 32'(2));
        cyc(1, 1, 12'h003, 1, 2, 0, 0, 1);
        chk("plan_g_repair", 32'(bus_g.predict_hist), 32'(0));

        for (int n = 0; n < 2000 && lc[0] < 66; n++) rand_cyc(0);
        chk("b_lc_0x42", 32'(bus_b.lookup_count), 32'h42);
        for (int n = 0; n < 300; n++) rand_cyc(1);
        if (ghr[1] == 0) cyc(1, 0, 0, 1, 0, 7, 1, 0);

        // Asynchronous reset between edges, with an update held across the next edge.
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_b_lc", 32'(bus_b.lookup_count), 32'(0));
        chk("arst_b_mc", 32'(bus_b.mispredict_count), 32'(0));
        chk("arst_g_lc", 32'(bus_g.lookup_count), 32'(0));
        chk("arst_g_hist", 32'(bus_g.predict_hist), 32'(0));
        for (int p = 0; p < 16; p++) begin
            bus_b.lookup_pc = 12'(p); bus_g.lookup_pc = 12'(p);
            #1;
            chk("arst_b_entry", 32'(bus_b.predict_taken), 32'(0));
            chk("arst_g_entry", 32'(bus_g.predict_taken), 32'(0));
            chk("arst_g_idx", 32'(bus_g.predict_index), 32'(p));
        end
        bus_b.lookup_valid = 1; bus_b.update_valid = 1; bus_b.update_index = 4'd0; bus_b.update_taken = 1;
        bus_b.lookup_pc = 12'h000;
        @(posedge clk);
        #1;
        chk("arst_wins_lc", 32'(bus_b.lookup_count), 32'(0));
        chk("arst_wins_mc", 32'(bus_b.mispredict_count), 32'(0));
        rst_n = 1'b1;
        idle_all();
        @(posedge clk);
        #1;

        // Both entry 0 counters are still weakly-not-taken: one taken update flips the prediction.
        cyc(0, 0, 0, 1, 0, 0, 1, 1);
        cyc(0, 1, 12'h000, 0, 0, 0, 0, 0);
        chk("post_rst_entry0", 32'(last_pt), 32'(1));

        for (int n = 0; n < 20; n++) cyc(1, 1, int'($urandom_range(0, 4095)), 0, 0, 0, 0, 0);
        chk("g_lc_saturate", 32'(bus_g.lookup_count), 32'hF);
        for (int n = 0; n < 200; n++) rand_cyc(0);
        for (int n = 0; n < 200; n++) rand_cyc(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Parametrised dynamic branch predictor that replaces the static, opcode-based prediction in the pipelined datapath. It holds a table of saturating direction counters, indexed by the branch PC and optionally XOR-folded with a speculative global history register (gshare mode). Lookup happens in the ID stage. Resolution and update come from the EX stage one or more cycles later and raise a same-cycle mispredict for the flush logic. The block also keeps saturating lookup and mispredict statistics.

## Interface
- ADDRESS_LEN, 12: PC width.
- INDEX_BITS, 4: table index width; ENTRIES = 2**INDEX_BITS.
- CTR_BITS, 2: counter width, at least 2.
- HIST_LEN, 0: global history length. 0 selects bimodal mode; 1..INDEX_BITS selects gshare mode.
- STAT_WIDTH, 16: statistics counter width.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  a branch is in ID this cycle and is not stalled.
- lookup_pc  in  ADDRESS_LEN  PC of that branch.
- predict_taken  out  1  combinational; MSB of the indexed counter.
- predict_index  out  INDEX_BITS  combinational index; the pipeline carries it to EX.
- predict_hist  out  max(HIST_LEN,1)  GHR value used for this lookup; carried to EX.
- update_valid  in  1  a branch resolves in EX this cycle.
- update_index  in  INDEX_BITS  carried predict_index.
- update_hist  in  max(HIST_LEN,1)  carried predict_hist.
- update_taken  in  1  actual branch outcome.
- update_predicted  in  1  carried predict_taken.
- mispredict  out  1  combinational; update_valid & (update_taken != update_predicted).
- lookup_count  out  STAT_WIDTH  saturating count of lookups.
- mispredict_count  out  STAT_WIDTH  saturating count of mispredictions.

## Operation
- Index:
  - Bimodal: lookup_pc[INDEX_BITS-1:0].
  - Gshare: lookup_pc[INDEX_BITS-1:0] XOR the GHR zero-extended to INDEX_BITS.
- Counters:
  - Unsigned and saturating. Taken increments up to 2**CTR_BITS-1; not-taken decrements down to 0.
  - Reset value is weakly-not-taken, 2**(CTR_BITS-1)-1 (01 for 2 bits).
- Update: when update_valid is high, the counter at update_index moves by update_taken at the clock edge.
- GHR (gshare mode only), next value in priority order:
  - On mispredict: {update_hist[HIST_LEN-2:0], update_taken}. This repairs the speculative history and overrides any lookup in the same cycle, because that lookup is being flushed.
  - Otherwise, on lookup_valid: {GHR[HIST_LEN-2:0], predict_taken}.
  - Otherwise: hold.
- In bimodal mode the GHR does not exist and predict_hist is driven to 0.
- Statistics:
  - lookup_count increments on lookup_valid.
  - mispredict_count increments on mispredict.
  - Both saturate at all-ones and never wrap.
- Same-index collision: when a lookup and an update target the same entry in one cycle, the lookup sees the pre-update counter. There is no bypass.
- Two updates to the same entry in consecutive cycles each apply in order. The second update sees the result of the first.

## Timing
- Prediction latency is 0 cycles; predict_* is combinational from lookup_pc and state.
- Counter update, GHR and statistics take effect 1 cycle after the update or lookup cycle.
- mispredict is asserted in the same cycle as update_valid, so the flush takes effect at that edge.
- Reset:
  - Asynchronous assert: all counters go to weakly-not-taken, GHR=0, lookup_count=0, mispredict_count=0.
  - Outputs reflect the reset state immediately, without waiting for a clock edge.
  - Reset wins over any concurrent lookup or update.
- Deassertion of rst is synchronised externally. The first active edge after deassertion is treated as a normal cycle.
- Inputs other than rst are sampled only on the rising edge.

## Structure
- Shared `defines.sv` holds ADDRESS_LEN.
- Package bp_pkg holds:
  - the counter reset-value function ctr_init(CTR_BITS);
  - the STAT_WIDTH default;
  - the typedef for the GHR width rule max(HIST_LEN,1).
- Sub-module sat_counter (parametrised width, inc/dec/hold, asynchronous active-low reset to a parameter value). It is used for every table entry and for both statistics counters.
- The table is a generate loop of ENTRIES sat_counter instances, each enabled by update_valid & (update_index == i).

## Test plan
- Post-reset lookup, defaults: lookup_pc=0x005 → predict_taken=0, predict_index=5. Every entry reads 01.
- Training and saturation:
  - Two taken updates at index 5 → the next lookup of 0x005 gives predict_taken=1.
  - A third taken update → the counter stays 11.
  - One not-taken update → the counter is 10 and predict_taken is still 1.
- Mispredict: update_valid=1, update_predicted=0, update_taken=1 → mispredict=1 in the same cycle; mispredict_count goes 0→1 at the next edge.
- Gshare repair, HIST_LEN=4:
  - Counter 3 is trained to 11. Lookup 0x003 → predict_taken=1; the GHR becomes 0001.
  - Next lookup 0x003 → predict_index=2.
  - In the following cycle, a mispredict with update_hist=0000 and update_taken=0 arrives together with a lookup → the GHR becomes 0000, not a shifted value.
- Collision: in one cycle, lookup 0x007 and update index 7 taken with the counter at 01 → predict_taken=0 that cycle; the next lookup gives 1.
- Asynchronous reset mid-run:
  - With lookup_count=0x0042 and the GHR non-zero, pull rst low between edges → counts=0, GHR=0 and all entries=01 immediately.
  - With STAT_WIDTH=4, 20 lookups → lookup_count holds at 0xF.
